// File: rtl/bp_upd_pkg.sv
// Shared types and default constants for the branch-predictor counter updater.
package bp_upd_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } upd_state_e;

  localparam int unsigned DEF_INDEX    = 6;
  localparam int unsigned DEF_CTR_W    = 2;
  localparam int unsigned DEF_INIT_VAL = 2;

endpackage

// File: rtl/bp_sat_ctr.sv
// Combinational saturating up/down step for a CTR_W-bit predictor counter.
module bp_sat_ctr #(
  parameter int unsigned CTR_W = 2
) (
  input  logic [CTR_W-1:0] old_val,
  input  logic             taken,
  output logic [CTR_W-1:0] new_val
);

  function automatic logic [CTR_W-1:0] sat_step(input logic [CTR_W-1:0] v, input logic up);
    logic [CTR_W-1:0] r;
    r = v;
    if (up) begin
      if (v != '1) r = v + CTR_W'(1);
    end else begin
      if (v != '0) r = v - CTR_W'(1);
    end
    return r;
  endfunction

  assign new_val = sat_step(old_val, taken);

endmodule

// File: rtl/bp_ctr_updater.sv
// Initialises the predictor counter RAM, then applies saturating read-modify-write updates.
// Optional update/saturation statistics ports are enabled with BP_UPD_STATS_EN.
module bp_ctr_updater
  import bp_upd_pkg::*;
#(
  parameter int unsigned DEPTH    = 64,
  parameter int unsigned INDEX    = DEF_INDEX,
  parameter int unsigned CTR_W    = DEF_CTR_W,
  parameter int unsigned INIT_VAL = DEF_INIT_VAL
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             upd_valid_i,
  output logic             upd_ready_o,
  input  logic [INDEX-1:0] upd_idx_i,
  input  logic             upd_taken_i,
  output logic [INDEX-1:0] ram_addr_o,
  input  logic [CTR_W-1:0] ram_data_i,
  output logic [INDEX-1:0] ram_waddr_o,
  output logic [CTR_W-1:0] ram_wdata_o,
  output logic             ram_we_o,
  output logic             init_done_o
`ifdef BP_UPD_STATS_EN
  ,
  output logic [31:0]      upd_cnt_o,
  output logic [31:0]      sat_cnt_o
`endif
);

  localparam logic [INDEX-1:0] LAST_IDX = INDEX'(DEPTH - 1);

  upd_state_e       state_q, state_d;
  logic [INDEX-1:0] ptr_q, ptr_d;
  logic             sweep_en_q;
  logic             init_write;
  logic             accept;

  logic             vld_p1;
  logic [INDEX-1:0] idx_p1;
  logic             taken_p1;
  logic [CTR_W-1:0] old_p1;
  logic [CTR_W-1:0] nxt_p1;

  logic             vld_p2;
  logic [INDEX-1:0] idx_p2;
  logic [CTR_W-1:0] val_p2;

  // sweep_en_q keeps the write port quiet for the first cycle after reset release,
  // so no write strobe is ever presented while reset is held.
  assign init_write  = (state_q == ST_INIT) && sweep_en_q;
  assign upd_ready_o = (state_q == ST_RUN);
  assign init_done_o = (state_q == ST_RUN);
  assign accept      = upd_valid_i && upd_ready_o;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      ST_INIT: begin
        if (sweep_en_q) begin
          if (ptr_q == LAST_IDX) state_d = ST_RUN;
          else                   ptr_d   = ptr_q + INDEX'(1);
        end
      end
      ST_RUN: ;
      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_INIT;
      ptr_q      <= '0;
      sweep_en_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      sweep_en_q <= 1'b1;
    end
  end

  // Stage p1: read old counter; forward the in-flight write when it targets the same entry
  assign ram_addr_o = idx_p1;
  assign old_p1     = (vld_p2 && (idx_p2 == idx_p1)) ? val_p2 : ram_data_i;

  bp_sat_ctr #(.CTR_W(CTR_W)) u_sat_ctr (
    .old_val (old_p1),
    .taken   (taken_p1),
    .new_val (nxt_p1)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_p1   <= 1'b0;
      idx_p1   <= '0;
      taken_p1 <= 1'b0;
      vld_p2   <= 1'b0;
      idx_p2   <= '0;
      val_p2   <= '0;
    end else begin
      vld_p1 <= accept;
      if (accept) begin
        idx_p1   <= upd_idx_i;
        taken_p1 <= upd_taken_i;
      end
      vld_p2 <= vld_p1;
      if (vld_p1) begin
        idx_p2 <= idx_p1;
        val_p2 <= nxt_p1;
      end
    end
  end

  // Stage p2: write port shared between the init sweep and update write-back
  assign ram_we_o    = init_write || vld_p2;
  assign ram_waddr_o = init_write ? ptr_q : idx_p2;
  assign ram_wdata_o = init_write ? CTR_W'(INIT_VAL) : val_p2;

`ifdef BP_UPD_STATS_EN
  logic        sat_p2;
  logic [31:0] upd_cnt_q;
  logic [31:0] sat_cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sat_p2    <= 1'b0;
      upd_cnt_q <= '0;
      sat_cnt_q <= '0;
    end else begin
      if (vld_p1) sat_p2 <= (nxt_p1 == old_p1);
      if (vld_p2) begin
        upd_cnt_q <= upd_cnt_q + 32'd1;
        if (sat_p2) sat_cnt_q <= sat_cnt_q + 32'd1;
      end
    end
  end

  assign upd_cnt_o = upd_cnt_q;
  assign sat_cnt_o = sat_cnt_q;
`endif

endmodule

// File: tb/tb_bp_ctr_updater.sv
// Directed bench for bp_ctr_updater with a behavioural counter RAM.
module tb_bp_ctr_updater;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       upd_valid_i = 1'b0;
  logic       upd_ready_o;
  logic [5:0] upd_idx_i = '0;
  logic       upd_taken_i = 1'b0;
  logic [5:0] ram_addr_o;
  logic [1:0] ram_data_i;
  logic [5:0] ram_waddr_o;
  logic [1:0] ram_wdata_o;
  logic       ram_we_o;
  logic       init_done_o;
`ifdef BP_UPD_STATS_EN
  logic [31:0] upd_cnt_o;
  logic [31:0] sat_cnt_o;
`endif

  int n_cmp = 0;
  int n_err = 0;

  logic [1:0] mem [64];

  logic       rv [8];
  logic [5:0] ri [8];
  logic       rt [8];
  logic [5:0] ea [8];
  logic [1:0] ed [8];

  bp_ctr_updater dut (
    .clk         (clk),
    .reset       (reset),
    .upd_valid_i (upd_valid_i),
    .upd_ready_o (upd_ready_o),
    .upd_idx_i   (upd_idx_i),
    .upd_taken_i (upd_taken_i),
    .ram_addr_o  (ram_addr_o),
    .ram_data_i  (ram_data_i),
    .ram_waddr_o (ram_waddr_o),
    .ram_wdata_o (ram_wdata_o),
    .ram_we_o    (ram_we_o),
    .init_done_o (init_done_o)
`ifdef BP_UPD_STATS_EN
    ,
    .upd_cnt_o   (upd_cnt_o),
    .sat_cnt_o   (sat_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  assign ram_data_i = mem[ram_addr_o];
  always @(posedge clk) if (ram_we_o === 1'b1) mem[ram_waddr_o] <= ram_wdata_o;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic [5:0] idx, input logic tk,
                         input logic [1:0] d);
    rv[i] = v; ri[i] = idx; rt[i] = tk; ea[i] = idx; ed[i] = d;
  endtask

  task automatic check_sweep(input string tag);
    int w = 0;
    while (ram_we_o !== 1'b1 && w < 4) begin
      tick();
      w++;
    end
    check($sformatf("%s_start", tag), 32'(ram_we_o), 32'd1);
    for (int i = 0; i < 64; i++) begin
      check($sformatf("%s_we%0d", tag, i), 32'(ram_we_o), 32'd1);
      check($sformatf("%s_addr%0d", tag, i), 32'(ram_waddr_o), 32'(i));
      check($sformatf("%s_data%0d", tag, i), 32'(ram_wdata_o), 32'd2);
      check($sformatf("%s_rdy%0d", tag, i), 32'(upd_ready_o), 32'd0);
      check($sformatf("%s_done%0d", tag, i), 32'(init_done_o), 32'd0);
      tick();
    end
    check($sformatf("%s_done", tag), 32'(init_done_o), 32'd1);
    check($sformatf("%s_ready", tag), 32'(upd_ready_o), 32'd1);
    check($sformatf("%s_we_idle", tag), 32'(ram_we_o), 32'd0);
  endtask

  // Request k is presented in cycle k; its write strobe is expected in cycle k+2.
  task automatic run_vec(input int n, input string tag);
    for (int k = 0; k < n + 2; k++) begin
      if (k < n) begin
        upd_valid_i = rv[k]; upd_idx_i = ri[k]; upd_taken_i = rt[k];
      end else begin
        upd_valid_i = 1'b0;
      end
      if (k >= 2) begin
        if (rv[k-2]) begin
          check($sformatf("%s_we%0d", tag, k), 32'(ram_we_o), 32'd1);
          check($sformatf("%s_addr%0d", tag, k), 32'(ram_waddr_o), 32'(ea[k-2]));
          check($sformatf("%s_data%0d", tag, k), 32'(ram_wdata_o), 32'(ed[k-2]));
        end else begin
          check($sformatf("%s_we%0d", tag, k), 32'(ram_we_o), 32'd0);
        end
      end else begin
        check($sformatf("%s_we%0d", tag, k), 32'(ram_we_o), 32'd0);
      end
      tick();
    end
    upd_valid_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    tick();
    tick();
    check("rst_we", 32'(ram_we_o), 32'd0);
    check("rst_ready", 32'(upd_ready_o), 32'd0);
    check("rst_done", 32'(init_done_o), 32'd0);
    check("rst_waddr", 32'(ram_waddr_o), 32'd0);
    check("rst_wdata", 32'(ram_wdata_o), 32'd0);
    check("rst_raddr", 32'(ram_addr_o), 32'd0);
    reset = 1'b1;
    check_sweep("sweep0");

    // Forwarding chain on idx 5: 2 -> 3,3,3 then 2,1,0,0
    set_req(0, 1, 6'd5, 1, 2'd3);
    set_req(1, 1, 6'd5, 1, 2'd3);
    set_req(2, 1, 6'd5, 1, 2'd3);
    set_req(3, 1, 6'd5, 0, 2'd2);
    set_req(4, 1, 6'd5, 0, 2'd1);
    set_req(5, 1, 6'd5, 0, 2'd0);
    set_req(6, 1, 6'd5, 0, 2'd0);
    run_vec(7, "fwd");

    set_req(0, 1, 6'd7, 1, 2'd3);
    set_req(1, 1, 6'd9, 0, 2'd1);
    set_req(2, 1, 6'd7, 1, 2'd3);
    run_vec(3, "ilv");

    // Decrement then forwarded increment; then gap case reading the landed value
    set_req(0, 1, 6'd12, 0, 2'd1);
    set_req(1, 1, 6'd12, 1, 2'd2);
    set_req(2, 1, 6'd20, 0, 2'd1);
    set_req(3, 0, 6'd0, 0, 2'd0);
    set_req(4, 1, 6'd20, 0, 2'd0);
    run_vec(5, "mix");

    check("mem5", 32'(mem[5]), 32'd0);
    check("mem7", 32'(mem[7]), 32'd3);
    check("mem9", 32'(mem[9]), 32'd1);
    check("mem12", 32'(mem[12]), 32'd2);
    check("mem20", 32'(mem[20]), 32'd0);

    // Reset while both pipeline stages hold updates
    upd_valid_i = 1'b1; upd_idx_i = 6'd3; upd_taken_i = 1'b1;
    tick();
    upd_idx_i = 6'd4; upd_taken_i = 1'b0;
    tick();
    upd_valid_i = 1'b0;
    check("pipe_we", 32'(ram_we_o), 32'd1);
    check("pipe_addr", 32'(ram_waddr_o), 32'd3);
    #2 reset = 1'b0;
    #1;
    check("pipe_rst_we", 32'(ram_we_o), 32'd0);
    check("pipe_rst_done", 32'(init_done_o), 32'd0);
    tick();
    check("pipe_mem3", 32'(mem[3]), 32'd2);
    check("pipe_mem4", 32'(mem[4]), 32'd2);
    reset = 1'b1;
    check_sweep("sweep1");
    bad = 0;
    for (int i = 0; i < 64; i++) if (mem[i] !== 2'd2) bad++;
    check("mem_all_init", 32'(bad), 32'd0);

    // Reset in the middle of the sweep at pointer 30
    reset = 1'b0;
    tick();
    reset = 1'b1;
    begin
      int w = 0;
      while (ram_we_o !== 1'b1 && w < 4) begin
        tick();
        w++;
      end
    end
    for (int i = 0; i < 30; i++) tick();
    check("mid_we", 32'(ram_we_o), 32'd1);
    check("mid_addr30", 32'(ram_waddr_o), 32'd30);
    #2 reset = 1'b0;
    #1;
    check("mid_rst_we", 32'(ram_we_o), 32'd0);
    check("mid_rst_waddr", 32'(ram_waddr_o), 32'd0);
    check("mid_rst_done", 32'(init_done_o), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    check_sweep("sweep2");

`ifdef BP_UPD_STATS_EN
    check("stat_upd0", upd_cnt_o, 32'd0);
    check("stat_sat0", sat_cnt_o, 32'd0);
`endif
    set_req(0, 1, 6'd10, 1, 2'd3);
    set_req(1, 1, 6'd10, 1, 2'd3);
    set_req(2, 1, 6'd10, 1, 2'd3);
    run_vec(3, "sat");
`ifdef BP_UPD_STATS_EN
    check("stat_upd", upd_cnt_o, 32'd3);
    check("stat_sat", sat_cnt_o, 32'd2);
`endif
    check("mem10", 32'(mem[10]), 32'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
